page_table_walker: RTL and testbench
====================================

Name: page_table_walker

Overview:
- Two-level page table walker that sits between the TLB miss path and the word-addressed PTE memory.
- On a TLB miss it accepts a virtual address and issues one or two PTE reads over the memory's valid/ready request/response interface.
- It decodes each 32-bit PTE and returns a physical page number, permissions and a fault flag to the TLB refill logic.

Parameters:
- ROOT_PPN, 20'h00001, PPN of the root page table (root table at byte address 0x1000).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- walk_req_valid_i  input  1  TLB miss walk request valid
- walk_req_ready_o  output  1  walker can accept a request
- walk_vaddr_i  input  32  virtual address to translate
- walk_resp_valid_o  output  1  translation result valid
- walk_resp_ready_i  input  1  TLB accepts the result
- walk_ppn_o  output  20  translated PPN
- walk_perm_o  output  3  {X,W,R} from the leaf PTE
- walk_super_o  output  1  leaf found at level 1 (4 MB superpage)
- walk_fault_o  output  1  page fault
- mem_req_valid_o  output  1  PTE read request valid
- mem_req_ready_i  input  1  memory accepts the request
- mem_addr_o  output  32  PTE byte address
- mem_resp_valid_i  input  1  PTE data valid
- mem_resp_ready_o  output  1  walker accepts PTE data
- mem_data_i  input  32  PTE read data

Behaviour:
- Handshake rule: a transfer occurs on a rising clk edge when valid and ready are both high. Once raised, valid and its payload hold stable until the transfer completes.
- PTE format: [31:12] PPN, [3] X, [2] W, [1] R, [0] V. A PTE is a leaf if any of R/W/X is set.
- Reset values: walk_req_ready_o=1, all other outputs 0, state IDLE. Reset mid-walk abandons the walk and drops all valids on the next cycle. Memory is reset by the same rst.
- FSM states: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - walk_req_ready_o=1.
  - On accept: latch vaddr, drop ready, go to L1_REQ.
- L1_REQ:
  - mem_req_valid_o=1, mem_addr_o={ROOT_PPN, vaddr[31:22], 2'b00}.
  - On accept: go to L1_WAIT.
- L1_WAIT:
  - mem_resp_ready_o=1.
  - On response, decode the PTE:
    - V=0, or W=1 with R=0 -> fault.
    - Leaf with PPN[9:0]!=0 (misaligned superpage) -> fault.
    - Leaf, aligned -> ppn={PTE[31:22], vaddr[21:12]}, super=1.
    - Non-leaf -> latch PTE PPN, go to L2_REQ.
  - Fault and leaf cases go to RESP.
- L2_REQ:
  - mem_addr_o={pte_ppn, vaddr[21:12], 2'b00}, handshake as in L1_REQ.
- L2_WAIT:
  - V=0, or W&!R, or non-leaf -> fault.
  - Otherwise ppn=PTE[31:12], super=0.
  - Go to RESP.
- RESP:
  - walk_resp_valid_o=1; results are registered and held.
  - On accept: clear valid, set walk_req_ready_o=1, go to IDLE. A new request is not accepted in the same cycle.
- Output values on fault: walk_ppn_o=0, walk_perm_o=0, walk_super_o=0.
- mem_req_valid_o and mem_resp_ready_o are low outside their states. A memory response arriving outside a WAIT state is ignored.
- Only one walk is outstanding at a time. No PTE caching.
- Walker-internal latency, excluding memory wait: 1 cycle from request accept to mem_req_valid_o, and 1 cycle from final PTE to walk_resp_valid_o.

Optional Feature:
- PTW_STATS_EN defined: adds outputs walk_count_o[15:0] and fault_count_o[15:0].
  - walk_count_o increments on each completed walk response handshake.
  - fault_count_o increments on each completed handshake with fault=1.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- 4 KB page:
  - Stimulus: vaddr 0x0040_3123; PTE@0x1004=0x0000_2001; PTE@0x200C=0x0003_400F.
  - Required: two mem reads at 0x1004 then 0x200C; ppn=0x00034, perm=3'b111, super=0, fault=0.
- Superpage:
  - Stimulus: vaddr 0x0080_5000; PTE@0x1008=0x0040_0003.
  - Required: a single mem read; ppn=0x00405, perm=3'b001, super=1, fault=0.
- Invalid L1 PTE:
  - Stimulus: PTE@0x1004=0x0000_0000.
  - Required: one read, then fault=1, ppn=0.
- Misaligned superpage, then bad L2 PTE:
  - Stimulus: PTE 0x0040_1003 at L1.
  - Required: fault=1.
  - Stimulus: non-leaf L2 PTE 0x0000_5001.
  - Required: fault=1.
- Backpressure:
  - Stimulus: hold mem_req_ready_i=0 for 3 cycles and walk_resp_ready_i=0 for 5 cycles.
  - Required: mem_addr_o and the walk outputs stay stable; exactly one transfer occurs each time.
- Reset mid-walk:
  - Stimulus: assert rst in L2_WAIT.
  - Required: all valids 0 and walk_req_ready_o=1 next cycle; a following walk completes correctly. With PTW_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/page_table_walker.sv
// Two-level page table walker between the TLB miss path and word-addressed PTE memory.
// Accepts a virtual address, issues one or two PTE reads over a valid/ready memory
// interface, decodes the PTE and returns PPN, {X,W,R} permissions, a superpage flag
// and a fault flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   walk_req_*          TLB miss request (valid/ready) carrying walk_vaddr_i
//   walk_resp_*         translation result (valid/ready): walk_ppn_o, walk_perm_o,
//                       walk_super_o, walk_fault_o (registered and held while valid)
//   mem_req_*           PTE read request (valid/ready) carrying byte address mem_addr_o
//   mem_resp_*          PTE read response (valid/ready) carrying mem_data_i
//
// Optional build macro PTW_STATS_EN adds walk_count_o and fault_count_o, saturating
// 16-bit counters of completed walk responses and of completed faulting responses.
module page_table_walker #(
  parameter logic [19:0] ROOT_PPN = 20'h00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req_valid_i,
  output logic        walk_req_ready_o,
  input  logic [31:0] walk_vaddr_i,
  output logic        walk_resp_valid_o,
  input  logic        walk_resp_ready_i,
  output logic [19:0] walk_ppn_o,
  output logic [2:0]  walk_perm_o,
  output logic        walk_super_o,
  output logic        walk_fault_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
`ifdef PTW_STATS_EN
  output logic [15:0] walk_count_o,
  output logic [15:0] fault_count_o,
`endif
  input  logic [31:0] mem_data_i
);

  typedef enum logic [2:0] {StIdle, StL1Req, StL1Wait, StL2Req, StL2Wait, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [19:0] r_vpn;      // vaddr[31:12]; page offset is never needed
  logic [19:0] r_pte_ppn;  // next-level table PPN from a non-leaf L1 PTE
  logic [19:0] r_ppn;
  logic [2:0]  r_perm;
  logic        r_super;
  logic        r_fault;

  // PTE field decode on the incoming response data
  logic w_pte_leaf, w_pte_bad, w_l1_misaligned;
  assign w_pte_leaf      = |mem_data_i[3:1];
  assign w_pte_bad       = !mem_data_i[0] || (mem_data_i[2] && !mem_data_i[1]);
  assign w_l1_misaligned = (mem_data_i[21:12] != 10'd0);

  logic w_unused;
  assign w_unused = ^{walk_vaddr_i[11:0], mem_data_i[11:4]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    walk_req_ready_o  = 1'b0;
    walk_resp_valid_o = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_addr_o        = 32'd0;
    mem_resp_ready_o  = 1'b0;
    case (r_state)
      StIdle: begin
        walk_req_ready_o = 1'b1;
        if (walk_req_valid_i) w_state_next = StL1Req;
      end
      StL1Req: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {ROOT_PPN, r_vpn[19:10], 2'b00};
        if (mem_req_ready_i) w_state_next = StL1Wait;
      end
      StL1Wait: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          w_state_next = (w_pte_bad || w_pte_leaf) ? StResp : StL2Req;
        end
      end
      StL2Req: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {r_pte_ppn, r_vpn[9:0], 2'b00};
        if (mem_req_ready_i) w_state_next = StL2Wait;
      end
      StL2Wait: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) w_state_next = StResp;
      end
      StResp: begin
        walk_resp_valid_o = 1'b1;
        if (walk_resp_ready_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: capture the request and decode PTEs; results hold until the next walk ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpn     <= 20'd0;
      r_pte_ppn <= 20'd0;
      r_ppn     <= 20'd0;
      r_perm    <= 3'd0;
      r_super   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (walk_req_valid_i) r_vpn <= walk_vaddr_i[31:12];
        end
        StL1Wait: begin
          if (mem_resp_valid_i) begin
            if (w_pte_bad || (w_pte_leaf && w_l1_misaligned)) begin
              r_ppn   <= 20'd0;
              r_perm  <= 3'd0;
              r_super <= 1'b0;
              r_fault <= 1'b1;
            end else if (w_pte_leaf) begin
              // Superpage: upper PPN from the PTE, lower 10 bits pass through from vaddr
              r_ppn   <= {mem_data_i[31:22], r_vpn[9:0]};
              r_perm  <= mem_data_i[3:1];
              r_super <= 1'b1;
              r_fault <= 1'b0;
            end else begin
              r_pte_ppn <= mem_data_i[31:12];
            end
          end
        end
        StL2Wait: begin
          if (mem_resp_valid_i) begin
            if (w_pte_bad || !w_pte_leaf) begin
              r_ppn   <= 20'd0;
              r_perm  <= 3'd0;
              r_super <= 1'b0;
              r_fault <= 1'b1;
            end else begin
              r_ppn   <= mem_data_i[31:12];
              r_perm  <= mem_data_i[3:1];
              r_super <= 1'b0;
              r_fault <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign walk_ppn_o   = r_ppn;
  assign walk_perm_o  = r_perm;
  assign walk_super_o = r_super;
  assign walk_fault_o = r_fault;

`ifdef PTW_STATS_EN
  logic [15:0] r_walk_count, r_fault_count;
  logic        w_resp_hs;
  assign w_resp_hs = walk_resp_valid_o && walk_resp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_walk_count  <= 16'd0;
      r_fault_count <= 16'd0;
    end else if (w_resp_hs) begin
      if (r_walk_count != 16'hFFFF) r_walk_count <= r_walk_count + 16'd1;
      if (r_fault && (r_fault_count != 16'hFFFF)) r_fault_count <= r_fault_count + 16'd1;
    end
  end

  assign walk_count_o  = r_walk_count;
  assign fault_count_o = r_fault_count;
`endif

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed walks followed by randomized
// walks against a behavioural translation model over a sparse PTE memory.
module tb_page_table_walker;

  localparam int unsigned RootPpn = 1;

  logic        clk;
  logic        rst;
  logic        walk_req_valid_i;
  logic        walk_req_ready_o;
  logic [31:0] walk_vaddr_i;
  logic        walk_resp_valid_o;
  logic        walk_resp_ready_i;
  logic [19:0] walk_ppn_o;
  logic [2:0]  walk_perm_o;
  logic        walk_super_o;
  logic        walk_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;
`ifdef PTW_STATS_EN
  logic [15:0] walk_count_o;
  logic [15:0] fault_count_o;
`endif

  page_table_walker #(.ROOT_PPN(20'h00001)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .walk_req_valid_i  (walk_req_valid_i),
    .walk_req_ready_o  (walk_req_ready_o),
    .walk_vaddr_i      (walk_vaddr_i),
    .walk_resp_valid_o (walk_resp_valid_o),
    .walk_resp_ready_i (walk_resp_ready_i),
    .walk_ppn_o        (walk_ppn_o),
    .walk_perm_o       (walk_perm_o),
    .walk_super_o      (walk_super_o),
    .walk_fault_o      (walk_fault_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_ready_o  (mem_resp_ready_o),
`ifdef PTW_STATS_EN
    .walk_count_o      (walk_count_o),
    .fault_count_o     (fault_count_o),
`endif
    .mem_data_i        (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_walks = 0;
  int exp_faults = 0;

  logic [31:0] pte_mem [int unsigned];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (pte_mem.exists(a)) return pte_mem[a];
    return 32'd0;
  endfunction

  // Translation as the architecture describes it, in plain arithmetic.
  task automatic model_walk(input logic [31:0] va, output int n,
                            output logic [31:0] a0, output logic [31:0] d0,
                            output logic [31:0] a1, output logic [31:0] d1,
                            output logic [19:0] ppn, output logic [2:0] perm,
                            output logic sup, output logic fault);
    int unsigned rwx, v, r, w;
    a1 = 0; d1 = 0; ppn = 0; perm = 0; sup = 0; fault = 1;
    a0 = RootPpn * 4096 + (va >> 22) * 4;
    d0 = mem_rd(a0);
    n = 1;
    v = d0 % 2; rwx = (d0 >> 1) % 8; r = rwx % 2; w = (rwx >> 1) % 2;
    if (v == 0 || (w == 1 && r == 0)) return;
    if (rwx != 0) begin
      if (((d0 >> 12) % 1024) != 0) return;
      ppn = 20'((d0 >> 22) * 1024 + (va >> 12) % 1024);
      perm = 3'(rwx); sup = 1; fault = 0;
      return;
    end
    a1 = (d0 >> 12) * 4096 + ((va >> 12) % 1024) * 4;
    d1 = mem_rd(a1);
    n = 2;
    v = d1 % 2; rwx = (d1 >> 1) % 8; r = rwx % 2; w = (rwx >> 1) % 2;
    if (v == 0 || (w == 1 && r == 0) || rwx == 0) return;
    ppn = 20'(d1 >> 12); perm = 3'(rwx); sup = 0; fault = 0;
  endtask

  task automatic check_counters();
`ifdef PTW_STATS_EN
    check_val("walk_count", 32'(walk_count_o), exp_walks);
    check_val("fault_count", 32'(fault_count_o), exp_faults);
`endif
  endtask

  task automatic check_result(input string tag, input logic [19:0] ppn, input logic [2:0] perm,
                              input logic sup, input logic fault);
    check_val({tag, "_valid"}, 32'(walk_resp_valid_o), 1);
    check_val({tag, "_ppn"}, 32'(walk_ppn_o), 32'(ppn));
    check_val({tag, "_perm"}, 32'(walk_perm_o), 32'(perm));
    check_val({tag, "_super"}, 32'(walk_super_o), 32'(sup));
    check_val({tag, "_fault"}, 32'(walk_fault_o), 32'(fault));
  endtask

  // Runs one walk starting at a negedge with the walker idle. Every loop is fixed-length.
  task automatic do_walk(input logic [31:0] va, input int req_stall, input int resp_stall,
                         input bit rst_in_l2wait);
    int n, lat;
    logic [31:0] a0, d0, a1, d1, ea, ed;
    logic [19:0] e_ppn;
    logic [2:0]  e_perm;
    logic        e_sup, e_fault;
    model_walk(va, n, a0, d0, a1, d1, e_ppn, e_perm, e_sup, e_fault);

    walk_vaddr_i = va;
    walk_req_valid_i = 1'b1;
    check_val("req_ready_idle", 32'(walk_req_ready_o), 1);
    @(negedge clk);
    walk_req_valid_i = 1'b0;
    walk_vaddr_i = $urandom;
    check_val("req_ready_busy", 32'(walk_req_ready_o), 0);

    for (int k = 0; k < n; k++) begin
      ea = (k == 0) ? a0 : a1;
      ed = (k == 0) ? d0 : d1;
      check_val("mem_req_valid", 32'(mem_req_valid_o), 1);
      check_val("mem_addr", mem_addr_o, ea);
      for (int s = 0; s < req_stall; s++) begin
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1;  // stray response while not waiting: must be ignored
        mem_data_i = $urandom;
        check_val("mem_resp_ready_in_req", 32'(mem_resp_ready_o), 0);
        @(negedge clk);
        check_val("mem_req_hold", 32'(mem_req_valid_o), 1);
        check_val("mem_addr_hold", mem_addr_o, ea);
      end
      mem_resp_valid_i = 1'b0;
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      check_val("mem_req_once", 32'(mem_req_valid_o), 0);
      if (rst_in_l2wait && k == 1) begin
        rst = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_data_i = ed;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid_i = 1'b0;
        exp_walks = 0;
        exp_faults = 0;
        check_val("rst_mid_req_ready", 32'(walk_req_ready_o), 1);
        check_val("rst_mid_resp_valid", 32'(walk_resp_valid_o), 0);
        check_val("rst_mid_mem_req_valid", 32'(mem_req_valid_o), 0);
        check_val("rst_mid_mem_resp_ready", 32'(mem_resp_ready_o), 0);
        check_val("rst_mid_ppn", 32'(walk_ppn_o), 0);
        check_counters();
        return;
      end
      lat = $urandom_range(0, 2);
      repeat (lat) begin
        check_val("mem_resp_ready_wait", 32'(mem_resp_ready_o), 1);
        @(negedge clk);
      end
      mem_resp_valid_i = 1'b1;
      mem_data_i = ed;
      check_val("mem_resp_ready", 32'(mem_resp_ready_o), 1);
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      mem_data_i = 32'd0;
      check_val("mem_resp_ready_drop", 32'(mem_resp_ready_o), 0);
    end

    check_val("mem_req_after_walk", 32'(mem_req_valid_o), 0);
    check_result("resp", e_ppn, e_perm, e_sup, e_fault);
    for (int s = 0; s < resp_stall; s++) begin
      walk_resp_ready_i = 1'b0;
      @(negedge clk);
      check_result("resp_hold", e_ppn, e_perm, e_sup, e_fault);
    end
    walk_resp_ready_i = 1'b1;
    @(negedge clk);
    walk_resp_ready_i = 1'b0;
    exp_walks++;
    if (e_fault) exp_faults++;
    check_val("resp_valid_drop", 32'(walk_resp_valid_o), 0);
    check_val("req_ready_back", 32'(walk_req_ready_o), 1);
    check_counters();
  endtask

  function automatic logic [2:0] leaf_perm(input logic [2:0] p);
    // Any non-zero {X,W,R} except the reserved W-only encoding
    if (p == 3'b000 || p == 3'b010) return 3'b001;
    return p;
  endfunction

  initial begin
    logic [31:0] va, r, r2, l1a, l2a, pte;
    logic [19:0] nppn;
    int kind;

    rst = 1'b1;
    walk_req_valid_i = 1'b0;
    walk_vaddr_i = 32'd0;
    walk_resp_ready_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_data_i = 32'd0;
    repeat (2) @(negedge clk);
    check_val("reset_req_ready", 32'(walk_req_ready_o), 1);
    check_val("reset_resp_valid", 32'(walk_resp_valid_o), 0);
    check_val("reset_mem_req_valid", 32'(mem_req_valid_o), 0);
    check_val("reset_mem_resp_ready", 32'(mem_resp_ready_o), 0);
    check_val("reset_mem_addr", mem_addr_o, 0);
    check_val("reset_ppn", 32'(walk_ppn_o), 0);
    check_val("reset_perm", 32'(walk_perm_o), 0);
    check_val("reset_super", 32'(walk_super_o), 0);
    check_val("reset_fault", 32'(walk_fault_o), 0);
    check_counters();
    rst = 1'b0;

    // 4 KB page with request and response backpressure
    pte_mem[32'h1004] = 32'h0000_2001;
    pte_mem[32'h200C] = 32'h0003_400F;
    do_walk(32'h0040_3123, 3, 5, 1'b0);
    // Superpage
    pte_mem[32'h1008] = 32'h0040_0003;
    do_walk(32'h0080_5000, 0, 0, 1'b0);
    // Invalid L1 PTE
    pte_mem[32'h1004] = 32'h0000_0000;
    do_walk(32'h0040_3123, 1, 0, 1'b0);
    // Misaligned superpage
    pte_mem[32'h1004] = 32'h0040_1003;
    do_walk(32'h0040_3123, 0, 1, 1'b0);
    // Non-leaf L2 PTE
    pte_mem[32'h1004] = 32'h0000_2001;
    pte_mem[32'h200C] = 32'h0000_5001;
    do_walk(32'h0040_3123, 0, 0, 1'b0);
    // Reset in L2 wait, then a clean walk
    pte_mem[32'h200C] = 32'h0003_400F;
    do_walk(32'h0040_3123, 0, 0, 1'b1);
    do_walk(32'h0040_3123, 1, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      va = $urandom;
      r = $urandom;
      r2 = $urandom;
      l1a = RootPpn * 4096 + (va >> 22) * 4;
      kind = $urandom_range(0, 4);
      case (kind)
        0: pte = r & 32'hFFFF_FFFE;
        1: pte = {r[31:4], 4'b0101};
        2: pte = {r[31:22], r[21:12] | 10'h001, r[11:4], leaf_perm(r[3:1]), 1'b1};
        3: pte = {r[31:22], 10'h000, r[11:4], leaf_perm(r[3:1]), 1'b1};
        default: begin
          // Table PPN >= 0x10 keeps L2 tables clear of the root table
          nppn = {r[31:16] | 16'h0001, r[15:12]};
          pte = {nppn, r[11:4], 3'b000, 1'b1};
          l2a = 32'(nppn) * 4096 + ((va >> 12) % 1024) * 4;
          case ($urandom_range(0, 3))
            0: pte_mem[l2a] = r2 & 32'hFFFF_FFFE;
            1: pte_mem[l2a] = {r2[31:4], 4'b0101};
            2: pte_mem[l2a] = {r2[31:4], 4'b0001};
            default: pte_mem[l2a] = {r2[31:4], leaf_perm(r2[3:1]), 1'b1};
          endcase
        end
      endcase
      pte_mem[l1a] = pte;
      do_walk(va, $urandom_range(0, 3), $urandom_range(0, 5), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
